// File: rtl/mm_pkg.sv
// mm_pkg: shared FSM encoding, verify status codes and timing defaults for the
// MAC Merge verify/respond controller.
package mm_pkg;
    localparam int TICKS_PER_MS_DEF = 125000;

    typedef logic [2:0] state_t;
    typedef logic [2:0] status_t;

    localparam state_t ST_INIT     = 3'd0;
    localparam state_t ST_SEND     = 3'd1;
    localparam state_t ST_WAIT     = 3'd2;
    localparam state_t ST_VERIFIED = 3'd3;
    localparam state_t ST_FAILED   = 3'd4;
    localparam state_t ST_DISABLED = 3'd5;

    localparam status_t VERIFY_STATUS_INIT      = 3'd0;
    localparam status_t VERIFY_STATUS_VERIFYING = 3'd1;
    localparam status_t VERIFY_STATUS_SUCCEEDED = 3'd2;
    localparam status_t VERIFY_STATUS_FAILED    = 3'd3;
    localparam status_t VERIFY_STATUS_DISABLED  = 3'd4;

    function automatic status_t status_of(input state_t st);
        return (st == ST_SEND || st == ST_WAIT) ? VERIFY_STATUS_VERIFYING :
               st == ST_VERIFIED                ? VERIFY_STATUS_SUCCEEDED :
               st == ST_FAILED                  ? VERIFY_STATUS_FAILED :
               st == ST_DISABLED                ? VERIFY_STATUS_DISABLED :
                                                  VERIFY_STATUS_INIT;
    endfunction
endpackage

// File: rtl/mm_verify_respond_if.sv
// mm_verify_respond_if: management, receive-process and transmit-process signals
// of the verify/respond controller; slave is the controller's view.
interface mm_verify_respond_if;
    logic       p_enable;
    logic       disable_verify;
    logic [6:0] verify_time;
    logic       link_fail;
    logic       rcv_v;
    logic       rcv_r;
    logic       tx_v_done;
    logic       tx_r_done;
    logic       send_v;
    logic       send_r;
    logic       p_active;
    logic [2:0] verify_status;
    logic [1:0] verify_cnt;

    modport master (
        output p_enable, disable_verify, verify_time, link_fail,
        output rcv_v, rcv_r, tx_v_done, tx_r_done,
        input  send_v, send_r, p_active, verify_status, verify_cnt
    );

    modport slave (
        input  p_enable, disable_verify, verify_time, link_fail,
        input  rcv_v, rcv_r, tx_v_done, tx_r_done,
        output send_v, send_r, p_active, verify_status, verify_cnt
    );
endinterface

// File: rtl/mm_ms_timer.sv
// mm_ms_timer: loadable millisecond down-counter; the count holds verify_time
// scaled to clk ticks and drops one millisecond per prescaler wrap.
module mm_ms_timer import mm_pkg::*; #(
    parameter int TICKS_PER_MS = TICKS_PER_MS_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       start,
    input  logic [6:0] ms,
    output logic       done
);
    localparam int          PW    = TICKS_PER_MS > 1 ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [23:0] TICKS = 24'(TICKS_PER_MS);

    logic [PW-1:0] psc_q, psc_d;
    logic [23:0]   cnt_q, cnt_d;
    logic          wrap;

    always_comb begin
        wrap  = start && psc_q == PW'(TICKS_PER_MS - 1);
        psc_d = load ? '0 : !start ? psc_q : wrap ? '0 : psc_q + 1'b1;
        // a programmed 0 ms behaves as 1 ms
        cnt_d = load ? 24'(ms == '0 ? 7'd1 : ms) * TICKS :
                wrap ? (cnt_q > TICKS ? cnt_q - TICKS : '0) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            psc_q <= '0;
            cnt_q <= '0;
        end else begin
            psc_q <= psc_d;
            cnt_q <= cnt_d;
        end

    assign done = cnt_q == '0;
endmodule

// File: rtl/mm_verify_respond.sv
// mm_verify_respond: MAC Merge verify/respond controller; runs the verify
// handshake to decide p_active and queues respond mPackets for received verifies.
module mm_verify_respond import mm_pkg::*; #(
    parameter int TICKS_PER_MS = TICKS_PER_MS_DEF,
    parameter int VERIFY_LIMIT = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    mm_verify_respond_if.slave  bus
);
    localparam logic [1:0] LIMIT = 2'(VERIFY_LIMIT);

    state_t     state_q, state_d;
    status_t    status_q, status_d;
    logic [1:0] cnt_q, cnt_d;
    logic       send_v_q, send_v_d;
    logic       send_r_q, send_r_d;
    logic       p_active_q, p_active_d;
    logic       dv_q;
    logic       timer_done;

    mm_ms_timer #(.TICKS_PER_MS(TICKS_PER_MS)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state_q == ST_SEND),
        .start   (state_q == ST_WAIT && !send_v_q),
        .ms      (bus.verify_time),
        .done    (timer_done)
    );

    always_comb begin
        state_d = state_q;
        if (state_q != ST_INIT && (bus.link_fail || !bus.p_enable || bus.disable_verify != dv_q))
            state_d = ST_INIT;
        else if (state_q == ST_INIT && bus.p_enable && !bus.link_fail)
            state_d = bus.disable_verify ? ST_DISABLED : ST_SEND;
        else if (state_q == ST_SEND)
            state_d = ST_WAIT;
        else if (state_q == ST_WAIT && bus.rcv_r)
            state_d = ST_VERIFIED;
        else if (state_q == ST_WAIT && timer_done)
            state_d = cnt_q < LIMIT ? ST_SEND : ST_FAILED;
        // outputs are registered images of the next state
        send_v_d   = state_d == ST_INIT ? 1'b0 : state_d == ST_SEND ? 1'b1 : send_v_q && !bus.tx_v_done;
        cnt_d      = state_d == ST_INIT ? '0 : (state_d == ST_SEND && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;
        p_active_d = state_d == ST_VERIFIED || state_d == ST_DISABLED;
        status_d   = status_of(state_d);
        send_r_d   = bus.link_fail ? 1'b0 : (bus.rcv_v && bus.p_enable) ? 1'b1 : bus.tx_r_done ? 1'b0 : send_r_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q    <= ST_INIT;
            status_q   <= VERIFY_STATUS_INIT;
            cnt_q      <= '0;
            send_v_q   <= 1'b0;
            send_r_q   <= 1'b0;
            p_active_q <= 1'b0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            cnt_q      <= cnt_d;
            send_v_q   <= send_v_d;
            send_r_q   <= send_r_d;
            p_active_q <= p_active_d;
            dv_q       <= bus.disable_verify;
        end

    assign bus.send_v        = send_v_q;
    assign bus.send_r        = send_r_q;
    assign bus.p_active      = p_active_q;
    assign bus.verify_status = status_q;
    assign bus.verify_cnt    = cnt_q;
endmodule

// File: tb/tb_mm_verify_respond.sv
// tb_mm_verify_respond: directed vector table plus hand-written retry, expiry-race
// and asynchronous-reset sequences for mm_verify_respond.
module tb_mm_verify_respond;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mm_verify_respond_if bus();

    mm_verify_respond #(.TICKS_PER_MS(10), .VERIFY_LIMIT(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic       pe, dv, lf, rv, rr, tvd, trd;
        logic [6:0] vt;
        logic [7:0] exp;
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vecs[18];

    function automatic vec_t mk(input logic pe, dv, lf, rv, rr, tvd, trd, input logic [6:0] vt,
                                input logic sv, sr, pa, input logic [2:0] st, input logic [1:0] c);
        return {pe, dv, lf, rv, rr, tvd, trd, vt, sv, sr, pa, st, c};
    endfunction

    function automatic logic [7:0] outs();
        return {bus.send_v, bus.send_r, bus.p_active, bus.verify_status, bus.verify_cnt};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got sv,sr,pa,st,cnt=%b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive(input logic pe, dv, lf, rv, rr, tvd, trd, input logic [6:0] vt);
        bus.p_enable = pe; bus.disable_verify = dv; bus.link_fail = lf;
        bus.rcv_v = rv; bus.rcv_r = rr; bus.tx_v_done = tvd; bus.tx_r_done = trd;
        bus.verify_time = vt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rises, last, age;
        vecs[0]  = mk(0,0,0,0,0,0,0, 1, 0,0,0, 3'd0, 2'd0);
        vecs[1]  = mk(1,0,0,0,0,0,0, 1, 1,0,0, 3'd1, 2'd1);
        vecs[2]  = mk(1,0,0,0,0,0,0, 1, 1,0,0, 3'd1, 2'd1);
        vecs[3]  = mk(1,0,0,0,0,1,0, 1, 0,0,0, 3'd1, 2'd1);
        vecs[4]  = mk(1,0,0,0,1,0,0, 1, 0,0,1, 3'd2, 2'd1);
        vecs[5]  = mk(1,0,0,0,0,0,0, 1, 0,0,1, 3'd2, 2'd1);
        vecs[6]  = mk(1,0,0,0,1,0,0, 1, 0,0,1, 3'd2, 2'd1);
        vecs[7]  = mk(1,0,0,1,0,0,0, 1, 0,1,1, 3'd2, 2'd1);
        vecs[8]  = mk(1,0,0,1,0,0,1, 1, 0,1,1, 3'd2, 2'd1);
        vecs[9]  = mk(1,0,0,0,0,0,1, 1, 0,0,1, 3'd2, 2'd1);
        vecs[10] = mk(1,0,0,1,0,0,0, 1, 0,1,1, 3'd2, 2'd1);
        vecs[11] = mk(1,0,1,0,0,0,0, 1, 0,0,0, 3'd0, 2'd0);
        vecs[12] = mk(1,0,0,0,0,0,0, 1, 1,0,0, 3'd1, 2'd1);
        vecs[13] = mk(1,0,0,0,0,0,0, 1, 1,0,0, 3'd1, 2'd1);
        vecs[14] = mk(0,0,0,1,0,0,0, 1, 0,0,0, 3'd0, 2'd0);
        vecs[15] = mk(1,1,0,0,0,0,0, 1, 0,0,1, 3'd4, 2'd0);
        vecs[16] = mk(1,1,0,0,0,0,0, 1, 0,0,1, 3'd4, 2'd0);
        vecs[17] = mk(1,0,0,0,0,0,0, 1, 0,0,0, 3'd0, 2'd0);

        drive(0,0,0,0,0,0,0, 7'd1);
        repeat (3) tick();
        chk("reset", outs(), 8'b0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].pe, vecs[i].dv, vecs[i].lf, vecs[i].rv, vecs[i].rr,
                  vecs[i].tvd, vecs[i].trd, vecs[i].vt);
            tick();
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // retries without a respond: three verifies ~20 clk apart, then FAILED
        rises = 0; last = -1; age = 0;
        drive(1,0,0,0,0,0,0, 7'd2);
        for (int c = 0; c < 200; c++) begin
            bus.tx_v_done = (age == 2);
            tick();
            bus.tx_v_done = 1'b0;
            age = bus.send_v ? age + 1 : 0;
            if (age == 1) begin
                rises++;
                if (last >= 0) chk_rng("retry_gap", c - last, 20, 25);
                last = c;
                chk_rng("retry_cnt", int'(bus.verify_cnt), rises, rises);
            end
            if (bus.verify_status == 3'd3) break;
        end
        chk_rng("verify_requests", rises, 3, 3);
        chk("failed", outs(), {1'b0, 1'b0, 1'b0, 3'd3, 2'd3});

        // rcv_r in the same cycle as timer expiry wins over a retry
        drive(0,0,0,0,0,0,0, 7'd2);
        tick();
        chk("restart_init", outs(), 8'b0);
        bus.p_enable = 1'b1;
        tick();
        chk("restart_send", outs(), {1'b1, 1'b0, 1'b0, 3'd1, 2'd1});
        for (int k = 1; k <= 23; k++) begin
            bus.tx_v_done = (k == 2);
            bus.rcv_r = (k == 23);
            tick();
            bus.tx_v_done = 1'b0;
            bus.rcv_r = 1'b0;
            if (k == 22) chk("pre_expiry", outs(), {1'b0, 1'b0, 1'b0, 3'd1, 2'd1});
        end
        chk("expiry_race", outs(), {1'b0, 1'b0, 1'b1, 3'd2, 2'd1});

        // asynchronous reset while send_v and send_r are both pending
        bus.rcv_v = 1'b1;
        tick();
        bus.rcv_v = 1'b0;
        bus.p_enable = 1'b0;
        tick();
        bus.p_enable = 1'b1;
        tick();
        tick();
        chk("wait_pending", outs(), {1'b1, 1'b1, 1'b0, 3'd1, 2'd1});
        #2 reset_n = 1'b0;
        #1 chk("async_reset", outs(), 8'b0);
        bus.p_enable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset", outs(), 8'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
